examp_req_feeder: RTL and testbench
===================================

Name: examp_req_feeder

Overview:
- Upstream stage that generates the request stream for one ExampIf port (the a_/b_ prefixed side of ExampMain).
- Accepts bytes from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head as req_val/req_dat and holds it stable until the interface returns an acknowledge on out.
- One instance is built per prefixed port.

Parameters:
- DEPTH, 4, total entries held, including the one being presented; power of 2, >= 2
- DW, 8, data width; must match req_dat (8)
- TIMEOUT, 64, cycles req_val may wait unacknowledged; used only with the optional feature; >= 2

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  synchronous reset, active-high
- in_val  input  1  producer data valid
- in_dat  input  DW  producer data
- in_rdy  output  1  feeder can accept; in_rdy = (level < DEPTH)
- req_val  output  1  request valid toward the interface; req_val = (level != 0)
- req_dat  output  DW  FIFO head data
- out  input  1  acknowledge from the interface (its out signal)
- level  output  $clog2(DEPTH+1)  current occupancy, registered
- stray_ack  output  1  one-cycle pulse: out seen while req_val low
- timeout  output  1  one-cycle pulse: head dropped by the watchdog; tied 0 without the feature

Behaviour:
- Reset (rst high at posedge), all registered:
  - level=0, rd_ptr=0, wr_ptr=0, stray_ack=0, timeout=0, watchdog=0.
  - Hence req_val=0 and in_rdy=1 in the following cycle. Storage contents are not reset.
  - Reset mid-operation discards all entries, including a presented unacknowledged one. Any ack that arrives in the cycle after reset counts as stray.
- Push: in_val && in_rdy at posedge. Writes mem[wr_ptr] and advances wr_ptr (wraps modulo DEPTH).
- Pop: req_val && out at posedge. Advances rd_ptr (wraps modulo DEPTH).
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- Latency: a byte pushed at edge N is visible on req_val/req_dat from cycle N+1 when the FIFO was empty. No combinational path from in_* to req_*.
- Presentation:
  - req_val is driven from registered level; req_dat = mem[rd_ptr].
  - While req_val=1 without a pop, req_dat is stable.
  - Back-to-back: after a pop at edge M with level>=2, the next entry is presented from M+1 with req_val staying high.
- Full: when level==DEPTH, in_rdy=0 and in_val is ignored, even if a pop occurs the same cycle (no pass-through when full). in_dat is don't-care when in_rdy=0.
- Empty: an ack while level==0 pops nothing and pulses stray_ack for exactly one cycle, the cycle after the ack edge. Continuous stray ack gives continuous stray_ack.
- States: implicit via level.
  - IDLE (level==0): req_val=0.
  - PRESENT (level>0): req_val=1.
  - IDLE->PRESENT on push; PRESENT->IDLE on pop with level==1 and no push. All other transitions stay in the current state.

Optional Feature:
- Macro: EXAMP_REQ_FEEDER_TIMEOUT_EN
- Defined: watchdog counter.
  - Clears on reset, on pop, and when req_val=0; increments each cycle req_val=1 without a pop.
  - When it reaches TIMEOUT-1 with req_val=1 and out=0, the head is force-popped at that edge (rd_ptr++, level--), the counter clears, and timeout pulses for one cycle.
  - An ack in the same cycle wins: normal pop, no timeout.
  - A push in the same cycle is handled as a simultaneous push+pop.
- Undefined: no counter logic; timeout constant 0; req_val held indefinitely.

Test Plan:
- Reset release, no stimulus -> level=0, req_val=0, in_rdy=1, stray_ack=0, timeout=0 for 10 cycles.
- Push 0x5A at edge N, out=0 -> req_val=1, req_dat=0x5A from N+1 and stable 20 cycles; out=1 one cycle -> req_val=0 next cycle, level=0.
- Push 0x01..0x04 (DEPTH=4) -> in_rdy=0 after 4th, 5th byte 0xFF rejected; hold out=1 -> req_dat 0x01,0x02,0x03,0x04 on consecutive cycles, req_val drops after 4th.
- level=2, push 0x10 and ack same cycle -> level stays 2, next head correct; repeat across pointer wrap with 12 bytes -> in-order output.
- out=1 with level=0 for 3 cycles -> stray_ack high exactly 3 cycles, one cycle delayed; level stays 0.
- With EXAMP_REQ_FEEDER_TIMEOUT_EN, TIMEOUT=8, one entry, out=0 -> timeout pulse at cycle 8 of presentation, level=0. Second run with ack at the final cycle -> no timeout. Without the macro -> req_val held 100 cycles, timeout=0.

Source files
------------

// File: rtl/examp_req_feeder.sv
// Request-side feeder for one ExampIf port: a small FIFO whose head is held on req_val/req_dat until acknowledged.
// Optional head-drop watchdog enabled by defining EXAMP_REQ_FEEDER_TIMEOUT_EN.
module examp_req_feeder #(
  parameter int DEPTH   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_val,
  input  logic [DW-1:0]              in_dat,
  output logic                       in_rdy,
  output logic                       req_val,
  output logic [DW-1:0]              req_dat,
  input  logic                       out,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       stray_ack,
  output logic                       timeout
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0 || TIMEOUT < 2) begin : g_bad_param
    $error("examp_req_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          push, pop, drop, adv;

  assign in_rdy  = (level < FULL);
  assign req_val = (level != '0);
  assign req_dat = mem[rd_ptr];
  assign push    = in_val && in_rdy;
  assign pop     = req_val && out;
  assign adv     = pop || drop;

`ifdef EXAMP_REQ_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT-1);
  logic [WW-1:0] wd;

  // An ack in the same cycle takes precedence over the watchdog drop.
  assign drop = req_val && !out && (wd == WD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= drop;
      if (!req_val || adv) wd <= '0;
      else                 wd <= wd + WW'(1);
    end
  end
`else
  assign drop    = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      stray_ack <= 1'b0;
    end else begin
      stray_ack <= out && !req_val;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (adv)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, adv})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: tb/tb_examp_req_feeder.sv
// Directed self-checking bench for examp_req_feeder (DEPTH=4).
module tb_examp_req_feeder;
`ifdef EXAMP_REQ_FEEDER_TIMEOUT_EN
  localparam int TO   = 8;
  localparam int HOLD = 5;
`else
  localparam int TO   = 64;
  localparam int HOLD = 20;
`endif

  logic       clk = 1'b0;
  logic       rst, in_val, out;
  logic [7:0] in_dat;
  logic       in_rdy, req_val, stray_ack, timeout;
  logic [7:0] req_dat;
  logic [2:0] level;

  int passed = 0;
  int total  = 0;
  logic [7:0] expq [$];

  examp_req_feeder #(.DEPTH(4), .DW(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_dat(in_dat), .in_rdy(in_rdy),
    .req_val(req_val), .req_dat(req_dat), .out(out), .level(level),
    .stray_ack(stray_ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL bench time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; in_val = 1'b0; in_dat = 8'h00; out = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_level", level, 0);
      chk("idle_req_val", req_val, 0);
      chk("idle_in_rdy", in_rdy, 1);
      chk("idle_stray", stray_ack, 0);
      chk("idle_timeout", timeout, 0);
    end

    // single byte, held until ack
    in_val = 1'b1; in_dat = 8'h5A;
    tick();
    in_val = 1'b0; in_dat = 8'h00;
    chk("single_level", level, 1);
    for (int i = 0; i < HOLD; i++) begin
      chk("single_val", req_val, 1);
      chk("single_dat", req_dat, 8'h5A);
      tick();
    end
    out = 1'b1;
    tick();
    out = 1'b0;
    chk("single_pop_val", req_val, 0);
    chk("single_pop_level", level, 0);
    chk("single_pop_stray", stray_ack, 0);

    // fill to full, reject extra, full+pop ignores push
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_dat = 8'(i + 1);
      tick();
    end
    chk("full_level", level, 4);
    chk("full_in_rdy", in_rdy, 0);
    in_dat = 8'hFF;
    tick();
    chk("full_reject_level", level, 4);
    chk("full_head", req_dat, 8'h01);
    in_dat = 8'hEE; out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", req_val, 1);
      chk("drain_dat", req_dat, 8'(i + 1));
      tick();
      in_val = 1'b0;
      if (i == 0) chk("full_pop_level", level, 3);
    end
    out = 1'b0;
    chk("drain_done_val", req_val, 0);
    chk("drain_done_level", level, 0);
    tick();
    chk("drain_stray", stray_ack, 0);

    // simultaneous push+pop at level 2, then across pointer wrap
    in_val = 1'b1; in_dat = 8'h20; tick();
    in_dat = 8'h21; tick();
    chk("pp_level_pre", level, 2);
    in_dat = 8'h10; out = 1'b1;
    tick();
    chk("pp_level", level, 2);
    chk("pp_head", req_dat, 8'h21);
    expq = '{8'h21, 8'h10};
    for (int i = 0; i < 12; i++) begin
      in_dat = 8'h30 + 8'(i);
      chk("wrap_dat", req_dat, expq[0]);
      tick();
      void'(expq.pop_front());
      expq.push_back(8'h30 + 8'(i));
      chk("wrap_level", level, 2);
    end
    in_val = 1'b0;
    chk("wrap_tail0", req_dat, 8'h3A);
    tick();
    chk("wrap_tail1", req_dat, 8'h3B);
    tick();
    out = 1'b0;
    chk("wrap_empty", level, 0);
    tick();

    // stray ack for 3 cycles
    out = 1'b1;
    chk("stray_pre", stray_ack, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_on", stray_ack, 1);
      chk("stray_level", level, 0);
    end
    out = 1'b0;
    tick();
    chk("stray_off", stray_ack, 0);

    // reset mid-operation discards entries; ack right after counts as stray
    in_val = 1'b1; in_dat = 8'h77; tick(); tick();
    in_val = 1'b0;
    chk("midrst_pre", level, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_val", req_val, 0);
    out = 1'b1; tick(); out = 1'b0;
    chk("midrst_stray", stray_ack, 1);
    chk("midrst_level2", level, 0);
    tick();

`ifdef EXAMP_REQ_FEEDER_TIMEOUT_EN
    // watchdog drops the head after TO presentation cycles
    in_val = 1'b1; in_dat = 8'h99; tick(); in_val = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    chk("wd_before", timeout, 0);
    chk("wd_before_val", req_val, 1);
    tick();
    chk("wd_pulse", timeout, 1);
    chk("wd_level", level, 0);
    tick();
    chk("wd_pulse_end", timeout, 0);
    // ack in the final cycle wins
    in_val = 1'b1; in_dat = 8'h9A; tick(); in_val = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    out = 1'b1; tick(); out = 1'b0;
    chk("wd_ack_timeout", timeout, 0);
    chk("wd_ack_level", level, 0);
    chk("wd_ack_stray", stray_ack, 0);
`else
    // without the watchdog the head is held indefinitely
    in_val = 1'b1; in_dat = 8'h99; tick(); in_val = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("hold_val", req_val, 1);
      chk("hold_timeout", timeout, 0);
    end
    chk("hold_dat", req_dat, 8'h99);
    out = 1'b1; tick(); out = 1'b0;
    chk("hold_pop", level, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
